synth_note_sequencer: RTL and testbench
=======================================

Name: synth_note_sequencer

Overview:
Autonomous note scheduler that drives the 8-bit one-hot note-select inputs of the sine-wave synthesizer. It holds a small programmable step table, with a note or rest and a duration per step. It plays the table at a fixed beat rate, once or looped. It enforces a release gap between steps so that the synth's rising-edge note detection retriggers correctly, including when the same note repeats.

Parameters:
STEPS, 16, number of step-table entries (power of 2)
ADDR_W, 4, log2(STEPS)
BEAT_DIV, 6250000, clk cycles per beat (8 beats/s at 50 MHz); must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
wr_en  input  1  step-table write strobe
wr_addr  input  ADDR_W  step index to write
wr_data  input  8  step word: [7]=play (0=rest), [6:4]=note index 0..7, [3:0]=dur (beats = dur+1)
last_step  input  ADDR_W  index of the final step of the sequence
loop_en  input  1  1 = wrap from last_step to step 0; 0 = stop after last_step
start  input  1  start playback at step 0 (level-sampled each cycle)
stop  input  1  abort playback
legato  input  1  gap-suppression request (used only with SEQ_LEGATO_EN)
note_out  output  8  one-hot note select to synth ui_in; 0 = silence
busy  output  1  high while not IDLE
step_idx  output  ADDR_W  index of the step currently sounding
step_strobe  output  1  one-cycle pulse at the start of every step
done  output  1  one-cycle pulse when a non-looped sequence finishes

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE; note_out=0, busy=0, step_idx=0, step_strobe=0, done=0.
  - Beat counter = 0, duration counter = 0.
  - All table entries cleared to 8'h00, which is a 1-beat rest.
- Step table:
  - Register array, written on any cycle with wr_en=1, including during playback.
  - The write is visible to a step fetch in the following cycle or later.
- FSM states: IDLE, GAP, PLAY.
- IDLE:
  - note_out=0.
  - If start=1 and stop=0: step_idx<=0 and go to GAP.
  - start while busy is ignored.
- GAP (exactly 1 cycle):
  - note_out=0.
  - step_strobe=1.
  - Latch the table word at step_idx into the current-step register.
  - Load the beat counter with BEAT_DIV-1 and the duration counter with dur.
  - Go to PLAY.
- PLAY:
  - note_out = play ? (8'b1 << note) : 8'h00.
  - The beat counter decrements each cycle. On 0 it reloads BEAT_DIV-1, and the duration counter decrements.
  - The step ends on the cycle where both counters are 0.
  - Step length from GAP entry to next GAP entry = (dur+1)*BEAT_DIV cycles exactly, with the gap included.
- End of step:
  - If step_idx != last_step: step_idx+1, go to GAP.
  - If step_idx == last_step and loop_en=1: step_idx<=0, go to GAP.
  - Otherwise: go to IDLE, done=1 for 1 cycle, note_out=0 from the next cycle.
  - loop_en is sampled at the end-of-last-step cycle only.
- Stop:
  - stop=1 in GAP or PLAY forces IDLE next cycle with note_out=0; no done pulse.
  - stop and start together: stop wins.
- Address wrap:
  - step_idx wraps modulo STEPS.
  - If last_step is changed mid-play to a value below step_idx, playback runs to STEPS-1, wraps to 0, and continues.
- Reset mid-operation: immediate return to reset state, table cleared.
- Latency:
  - start at cycle N gives GAP at N+1 and the first note on note_out at N+2.
  - At most one bit of note_out is ever set.

Optional Feature:
SEQ_LEGATO_EN:
- Defined:
  - When legato=1 at the end of a step and the next step is a played note different from the currently sounding note, GAP is skipped.
  - The FSM goes straight from PLAY into PLAY of the next step: the table word is fetched, counters are loaded, and step_strobe pulses in that cycle.
  - note_out switches directly to the new one-hot value.
  - The step length becomes exactly (dur+1)*BEAT_DIV cycles of PLAY.
  - Same note, rest, or legato=0: GAP is inserted as normal.
- Undefined: the legato port exists but is ignored; GAP always occurs.

Test Plan:
- BEAT_DIV=4; write step0=8'h80 (C, 1 beat), step1=8'hD1 (A, 2 beats); last_step=1, loop_en=0; pulse start -> note_out 0 for 1 cycle, 8'h01 for 3 cycles, 0 for 1 cycle, 8'h20 for 7 cycles; done pulses once; busy falls.
- Table cleared after reset; last_step=0; start -> note_out stays 0 for 4 cycles, done pulses, step_strobe pulsed once.
- step0=step1=8'hA0 (E), loop_en=1 -> note_out shows 8'h04 with a 1-cycle 0 gap every 4 cycles, wrapping indefinitely; step_idx toggles 0,1,0.
- stop asserted in PLAY of step1 -> note_out=0 and busy=0 next cycle; no done pulse. start+stop in the same cycle from IDLE -> stays IDLE.
- Overwrite step1 with 8'hF0 (C high) during step0 -> step1 plays 8'h80. rst asserted mid-play -> all outputs 0 next cycle and the table reads as rests.
- With SEQ_LEGATO_EN, legato=1, steps C then D -> note_out goes 8'h01 straight to 8'h02 with no zero cycle; with C then C, the gap is still present.

Source files
------------

// File: rtl/synth_note_sequencer.sv
// synth_note_sequencer: plays a programmable step table as one-hot note selects
// for the sine-wave synth, with a one-cycle release gap between steps so the
// synth's rising-edge note detection retriggers (even on repeated notes).
// Optional feature macro: SEQ_LEGATO_EN -- when defined, legato=1 skips the gap
// if the next step is a played note different from the one currently sounding.
module synth_note_sequencer #(
  parameter int STEPS    = 16,
  parameter int ADDR_W   = 4,
  parameter int BEAT_DIV = 6250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] last_step,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  input  logic              legato,
  output logic [7:0]        note_out,
  output logic              busy,
  output logic [ADDR_W-1:0] step_idx,
  output logic              step_strobe,
  output logic              done
);

  localparam int BW = $clog2(BEAT_DIV);
  localparam logic [BW-1:0] BEAT_RELOAD = BW'(BEAT_DIV - 1);
  // The step-start cycle (GAP) is itself the first tick of the first beat, so
  // the counter leaves it already one count down.
  localparam logic [BW-1:0] BEAT_FIRST  = BW'(BEAT_DIV - 2);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_PLAY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] step_idx_q, step_idx_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [3:0]        dur_q, dur_d;
  logic [7:0]        note_q, note_d;
  logic              busy_q, busy_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;

  logic [7:0]        table_q [STEPS];
  logic [7:0]        cur_word;
  logic [ADDR_W-1:0] next_idx;
  logic              is_last;
  logic              legato_skip;

  function automatic logic [7:0] word_onehot(input logic [7:0] w);
    return w[7] ? (8'h01 << w[6:4]) : 8'h00;
  endfunction

  // Step table: one register per entry, writable at any time, cleared by reset.
  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_table
      always_ff @(posedge clk) begin
        if (rst) begin
          table_q[gi] <= 8'h00;
        end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          table_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign cur_word = table_q[step_idx_q];
  assign is_last  = (step_idx_q == last_step);
  // Natural modulo-STEPS wrap also covers last_step moved below step_idx.
  assign next_idx = (is_last && loop_en) ? '0 : step_idx_q + 1'b1;

`ifdef SEQ_LEGATO_EN
  logic [7:0] nxt_word;
  assign nxt_word    = table_q[next_idx];
  assign legato_skip = legato && nxt_word[7] && (word_onehot(nxt_word) != note_q);
`else
  logic unused_legato;
  assign unused_legato = legato;
  assign legato_skip   = 1'b0;
`endif

  // Next-state and registered-output logic for the IDLE/GAP/PLAY sequencer.
  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    beat_d     = beat_q;
    dur_d      = dur_q;
    note_d     = note_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        note_d = 8'h00;
        if (start && !stop) begin
          state_d    = S_GAP;
          step_idx_d = '0;
          strobe_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          note_d  = 8'h00;
        end else begin
          state_d = S_PLAY;
          note_d  = word_onehot(cur_word);
          beat_d  = BEAT_FIRST;
          dur_d   = cur_word[3:0];
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          note_d  = 8'h00;
        end else if (beat_q != '0) begin
          beat_d = beat_q - 1'b1;
        end else if (dur_q != 4'd0) begin
          beat_d = BEAT_RELOAD;
          dur_d  = dur_q - 4'd1;
        end else if (is_last && !loop_en) begin
          state_d = S_IDLE;
          note_d  = 8'h00;
          done_d  = 1'b1;
        end else begin
          step_idx_d = next_idx;
          strobe_d   = 1'b1;
`ifdef SEQ_LEGATO_EN
          if (legato_skip) begin
            // The new step starts in PLAY, so its first cycle holds a full beat count.
            note_d = word_onehot(nxt_word);
            beat_d = BEAT_RELOAD;
            dur_d  = nxt_word[3:0];
          end else begin
            state_d = S_GAP;
            note_d  = 8'h00;
          end
`else
          state_d = S_GAP;
          note_d  = 8'h00;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        note_d  = 8'h00;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_idx_q <= '0;
      beat_q     <= '0;
      dur_q      <= 4'd0;
      note_q     <= 8'h00;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      beat_q     <= beat_d;
      dur_q      <= dur_d;
      note_q     <= note_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
    end
  end

  assign note_out    = note_q;
  assign busy        = busy_q;
  assign step_idx    = step_idx_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;

endmodule

// File: tb/tb_synth_note_sequencer.sv
// tb_synth_note_sequencer: table-driven and randomized checks of the note
// sequencer against a timeline model built from step words (BEAT_DIV=4).
module tb_synth_note_sequencer;
  localparam int B = 4;
`ifdef SEQ_LEGATO_EN
  localparam bit LEG_BUILD = 1'b1;
`else
  localparam bit LEG_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, loop_en, start, stop, legato;
  logic [3:0] wr_addr, last_step;
  logic [7:0] wr_data;
  logic [7:0] note_out;
  logic       busy, step_strobe, done;
  logic [3:0] step_idx;

  always #5 clk = ~clk;

  synth_note_sequencer #(.STEPS(16), .ADDR_W(4), .BEAT_DIV(B)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_step(last_step), .loop_en(loop_en), .start(start), .stop(stop),
    .legato(legato), .note_out(note_out), .busy(busy), .step_idx(step_idx),
    .step_strobe(step_strobe), .done(done)
  );

  typedef struct packed {
    logic [7:0] note;
    logic [3:0] idx;
    logic       strobe;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [3:0][7:0] st;
    logic [3:0]      last;
    logic            loop_en;
    logic            leg;
    int              win;
    int              exp_busy;
    int              exp_strobes;
    int              exp_dones;
    logic [7:0]      exp_first;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];
  logic [7:0] mtab [16];
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t cur_obs();
    obs_t o;
    o.note = note_out; o.idx = step_idx; o.strobe = step_strobe; o.busy = busy; o.done = done;
    return o;
  endfunction

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_step = '0;
    loop_en = 1'b0; start = 1'b0; stop = 1'b0; legato = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 32'(cur_obs()), 32'd0);
  endtask

  task automatic write_step(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Expected per-cycle outputs from the GAP cycle onward: each step lasts
  // (dur+1)*B cycles, its first cycle silent unless legato skips the gap.
  task automatic build_model(input logic [3:0] last, input logic lp, input logic leg, input int win);
    int idx, len;
    logic [7:0] w, oh, prev;
    bit gap, first;
    obs_t o;
    exp_q.delete();
    idx = 0; prev = 8'h00; first = 1'b1;
    while (exp_q.size() < win) begin
      w   = mtab[idx];
      oh  = w[7] ? (8'h01 << w[6:4]) : 8'h00;
      len = (int'(w[3:0]) + 1) * B;
      gap = !(LEG_BUILD && leg && !first && w[7] && (oh != prev));
      for (int k = 0; k < len; k++) begin
        o.note = (gap && k == 0) ? 8'h00 : oh;
        o.idx = 4'(idx); o.strobe = (k == 0); o.busy = 1'b1; o.done = 1'b0;
        exp_q.push_back(o);
      end
      prev = oh; first = 1'b0;
      if (idx == int'(last) && !lp) begin
        o.note = 8'h00; o.idx = 4'(idx); o.strobe = 1'b0; o.busy = 1'b0; o.done = 1'b1;
        exp_q.push_back(o);
        o.done = 1'b0;
        while (exp_q.size() < win) exp_q.push_back(o);
      end else if (idx == int'(last)) begin
        idx = 0;
      end else begin
        idx = (idx + 1) % 16;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit hand);
    int busy_n, strobe_n, done_n;
    logic [7:0] first_note;
    obs_t o;
    do_reset();
    for (int i = 0; i < 16; i++) mtab[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      mtab[i] = v.st[i];
      write_step(4'(i), v.st[i]);
    end
    last_step = v.last; loop_en = v.loop_en; legato = v.leg;
    build_model(v.last, v.loop_en, v.leg, v.win);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_n = 0; strobe_n = 0; done_n = 0; first_note = 8'hxx;
    for (int c = 0; c < v.win; c++) begin
      if (c > 0) tick();
      o = cur_obs();
      check($sformatf("%s_trace_c%0d", tag, c), 32'(o), 32'(exp_q[c]));
      if (o.busy === 1'b1) busy_n++;
      if (o.strobe === 1'b1) strobe_n++;
      if (o.done === 1'b1) done_n++;
      if (c == 1) first_note = o.note;
    end
    if (hand) begin
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
      check({tag, "_strobes"}, 32'(strobe_n), 32'(v.exp_strobes));
      check({tag, "_dones"}, 32'(done_n), 32'(v.exp_dones));
      check({tag, "_first_note"}, 32'(first_note), 32'(v.exp_first));
    end
    $display("[TB] %s last=%0d loop=%0d leg=%0d win=%0d busy=%0d strobes=%0d dones=%0d",
             tag, v.last, v.loop_en, v.leg, v.win, busy_n, strobe_n, done_n);
    stop = 1'b1; tick(); stop = 1'b0; legato = 1'b0; loop_en = 1'b0;
    tick();
  endtask

  initial begin
    int n, strobes, first_idx, win;
    vec_t rv;

    //           steps[3:0]     last  loop leg win busy strb done first
    vecs[0] = '{32'h0000_D180, 4'd1, 1'b0, 1'b0, 16, 12, 2, 1, 8'h01};
    vecs[1] = '{32'h0000_0000, 4'd0, 1'b0, 1'b0,  8,  4, 1, 1, 8'h00};
    vecs[2] = '{32'h0000_A0A0, 4'd1, 1'b1, 1'b0, 20, 20, 5, 0, 8'h04};
    vecs[3] = '{32'h0000_9080, 4'd1, 1'b0, 1'b1, 12,  8, 2, 1, 8'h01};
    vecs[4] = '{32'h0000_8080, 4'd1, 1'b0, 1'b1, 12,  8, 2, 1, 8'h01};
    vecs[5] = '{32'h0000_008F, 4'd0, 1'b0, 1'b0, 70, 64, 1, 1, 8'h01};
    vecs[6] = '{32'h00F0_01B0, 4'd2, 1'b0, 1'b0, 20, 16, 3, 1, 8'h08};

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Randomized tables checked only against the timeline model.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 4);
      win = 0;
      rv.st = '0;
      for (int i = 0; i < n; i++) begin
        rv.st[i] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3))};
        win += (int'(rv.st[i][3:0]) + 1) * B;
      end
      rv.last = 4'(n - 1);
      rv.loop_en = 1'($urandom_range(0, 1));
      rv.leg = 1'($urandom_range(0, 1));
      rv.win = rv.loop_en ? (2 * win + 1) : (win + 3);
      run_vec($sformatf("rand%0d", r), rv, 1'b0);
    end

    // Stop during PLAY of step1: silent and idle next cycle, no done.
    do_reset();
    write_step(4'd0, 8'h80); write_step(4'd1, 8'hD1);
    last_step = 4'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && !(step_idx == 4'd1 && note_out != 8'h00); i++) tick();
    check("stop_reach_step1", 32'(note_out), 32'h20);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_note", 32'(note_out), 32'h0);
    check("stop_busy", 32'(busy), 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) n++;
      tick();
    end
    check("stop_no_done", 32'(n), 32'd0);
    $display("[TB] stop-in-play sequence");

    // start together with stop from IDLE stays idle.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'h0);
    check("startstop_strobe", 32'(step_strobe), 32'h0);
    tick();
    check("startstop_note", 32'(note_out), 32'h0);
    $display("[TB] start+stop sequence");

    // Overwrite step1 while step0 plays; start while busy is ignored.
    do_reset();
    write_step(4'd0, 8'h83); write_step(4'd1, 8'hD0);
    last_step = 4'd1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    check("busy_start_idx", 32'(step_idx), 32'd0);
    check("busy_start_note", 32'(note_out), 32'h01);
    write_step(4'd1, 8'hF0);
    for (int i = 0; i < 40 && !(step_idx == 4'd1 && note_out != 8'h00); i++) tick();
    check("overwrite_note", 32'(note_out), 32'h80);
    $display("[TB] overwrite-during-play sequence");

    // Reset mid-play clears outputs and the table.
    do_reset();
    write_step(4'd0, 8'h8F);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midplay_note", 32'(note_out), 32'h01);
    rst = 1'b1; tick();
    check("midrst_outputs", 32'(cur_obs()), 32'd0);
    rst = 1'b0;
    last_step = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    check("cleared_strobe", 32'(step_strobe), 32'h1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (note_out !== 8'h00) n++;
    end
    check("cleared_rest", 32'(n), 32'd0);
    tick();
    check("cleared_done", 32'(done), 32'h1);
    $display("[TB] reset-mid-play sequence");

    // last_step moved below step_idx: run to 15, wrap, finish at the new last.
    do_reset();
    last_step = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && step_idx != 4'd2; i++) tick();
    check("lastchg_reach2", 32'(step_idx), 32'd2);
    last_step = 4'd1;
    strobes = 0; first_idx = -1;
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      tick();
      if (step_strobe === 1'b1) begin
        if (strobes == 0) first_idx = int'(step_idx);
        strobes++;
      end
    end
    check("lastchg_done", 32'(done), 32'h1);
    check("lastchg_final_idx", 32'(step_idx), 32'd1);
    check("lastchg_strobes", 32'(strobes), 32'd15);
    check("lastchg_first_idx", 32'(first_idx), 32'd3);
    $display("[TB] last_step-wrap sequence");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
